// File: rtl/fwd_ctrl_cp4_if.sv
// Handshake bundle between the cp4 ID/EX pipeline and its forwarding controller.
// FWD_PERF_CNT_EN adds the stall_cnt/fwd_cnt performance counter outputs.
interface fwd_ctrl_cp4_if #(
  parameter int REG_ADDR_W = 5
`ifdef FWD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic                  pipe_en;
  logic                  flush;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_we;
  logic                  id_is_load;
  logic [1:0]            ex_fwd_sel_a;
  logic [1:0]            ex_fwd_sel_b;
  logic                  load_use_stall;
  logic                  ex_bubble;
`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      fwd_cnt;
`endif

  modport master (
    output pipe_en, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_we, id_is_load,
    input  ex_fwd_sel_a, ex_fwd_sel_b, load_use_stall, ex_bubble
`ifdef FWD_PERF_CNT_EN
    , input stall_cnt, fwd_cnt
`endif
  );

  modport slave (
    input  pipe_en, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_we, id_is_load,
    output ex_fwd_sel_a, ex_fwd_sel_b, load_use_stall, ex_bubble
`ifdef FWD_PERF_CNT_EN
    , output stall_cnt, fwd_cnt
`endif
  );
endinterface

// File: rtl/fwd_ctrl_cp4.sv
// Operand-forwarding and load-use stall controller for the cp4 EX-stage operand muxes.
// FWD_PERF_CNT_EN adds saturating stall/forward performance counters.
module fwd_ctrl_cp4 #(
  parameter int REG_ADDR_W = 5
`ifdef FWD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic            clk,
  input logic            rst_n,
  fwd_ctrl_cp4_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } stage_t;

  // Select 3 (W+1 hold) is resolved from what W holds now, so the retired
  // entry itself never needs to be stored.
  stage_t     x_q, m_q, w_q;
  logic [1:0] sel_a_q, sel_b_q;
  logic [1:0] sel_a_d, sel_b_d;
  logic       bubble_q;
  logic       haz_a, haz_b, stall, insert;

  function automatic logic hit(stage_t s, logic [REG_ADDR_W-1:0] r);
    return s.valid & s.we & (s.rd == r) & (r != '0);
  endfunction

  function automatic logic [1:0] sel_for(logic used, logic [REG_ADDR_W-1:0] r,
                                         stage_t x, stage_t m, stage_t w);
    logic [1:0] s;
    s = 2'd0;
    if (used) begin
      if (hit(x, r) && !x.is_load) s = 2'd1;
      else if (hit(m, r))          s = 2'd2;
      else if (hit(w, r))          s = 2'd3;
    end
    return s;
  endfunction

  always_comb begin
    haz_a   = bus.id_use_rs1 & hit(x_q, bus.id_rs1) & x_q.is_load;
    haz_b   = bus.id_use_rs2 & hit(x_q, bus.id_rs2) & x_q.is_load;
    stall   = bus.id_valid & ~bus.flush & (haz_a | haz_b);
    insert  = bus.id_valid & ~bus.flush & ~stall;
    sel_a_d = sel_for(bus.id_use_rs1, bus.id_rs1, x_q, m_q, w_q);
    sel_b_d = sel_for(bus.id_use_rs2, bus.id_rs2, x_q, m_q, w_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      sel_a_q  <= 2'd0;
      sel_b_q  <= 2'd0;
      bubble_q <= 1'b1;
    end else if (bus.pipe_en) begin
      w_q <= m_q;
      m_q <= x_q;
      if (insert) begin
        x_q      <= '{valid: 1'b1, rd: bus.id_rd, we: bus.id_reg_we, is_load: bus.id_is_load};
        sel_a_q  <= sel_a_d;
        sel_b_q  <= sel_b_d;
        bubble_q <= 1'b0;
      end else begin
        x_q      <= '0;
        sel_a_q  <= 2'd0;
        sel_b_q  <= 2'd0;
        bubble_q <= 1'b1;
      end
    end
  end

  assign bus.ex_fwd_sel_a   = sel_a_q;
  assign bus.ex_fwd_sel_b   = sel_b_q;
  assign bus.ex_bubble      = bubble_q;
  assign bus.load_use_stall = stall;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (bus.pipe_en) begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (insert && ((sel_a_d | sel_b_d) != 2'd0) && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl_cp4.sv
// Directed vector bench for fwd_ctrl_cp4: per-cycle table plus an async-reset sequence.
module tb_fwd_ctrl_cp4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  fwd_ctrl_cp4_if #(.REG_ADDR_W(5)) bus ();

  fwd_ctrl_cp4 #(.REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pe;
    logic       fl;
    logic       vl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       stall;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       bub;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit pe, bit fl, bit vl, int rs1, int rs2, bit u1, bit u2,
                              int rd, bit we, bit ld, bit st, int sa, int sb, bit bub);
    vec_t v;
    v.pe = pe; v.fl = fl; v.vl = vl;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
    v.rd = 5'(rd); v.we = we; v.ld = ld;
    v.stall = st; v.sa = 2'(sa); v.sb = 2'(sb); v.bub = bub;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(vec_t v);
    bus.pipe_en    = v.pe;
    bus.flush      = v.fl;
    bus.id_valid   = v.vl;
    bus.id_rs1     = v.rs1;
    bus.id_rs2     = v.rs2;
    bus.id_use_rs1 = v.u1;
    bus.id_use_rs2 = v.u2;
    bus.id_rd      = v.rd;
    bus.id_reg_we  = v.we;
    bus.id_is_load = v.ld;
  endtask

  task automatic check_regs(string tag, int sa, int sb, bit bub);
    check({tag, ".sel_a"},  32'(bus.ex_fwd_sel_a), 32'(sa));
    check({tag, ".sel_b"},  32'(bus.ex_fwd_sel_b), 32'(sb));
    check({tag, ".bubble"}, 32'(bus.ex_bubble),    32'(bub));
  endtask

  initial begin
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // pe fl vl rs1 rs2 u1 u2 rd we ld | stall sa sb bub
    vecs.push_back(mk(1,0,1,  1,  2,1,1,  5,1,0, 0,0,0,0)); // add x5
    vecs.push_back(mk(1,0,1,  5,  3,1,1,  6,1,0, 0,1,0,0)); // distance 1
    vecs.push_back(mk(1,0,1,  0,  0,0,0,  9,1,0, 0,0,0,0)); // producer x9
    vecs.push_back(mk(1,0,1,  0,  0,0,0,  0,0,0, 0,0,0,0)); // filler
    vecs.push_back(mk(1,0,1,  9,  0,1,0,  0,0,0, 0,2,0,0)); // distance 2
    vecs.push_back(mk(1,0,1,  9,  0,1,1,  0,0,0, 0,3,0,0)); // distance 3
    vecs.push_back(mk(1,0,1,  9,  0,1,0,  0,0,0, 0,0,0,0)); // distance 4
    vecs.push_back(mk(1,0,1,  0,  0,0,0,  0,1,0, 0,0,0,0)); // writes x0
    vecs.push_back(mk(1,0,1,  0,  0,1,0, 12,1,0, 0,0,0,0)); // reads x0
    vecs.push_back(mk(1,0,1,  0, 12,0,0,  0,0,0, 0,0,0,0)); // rs2 match, unused
    vecs.push_back(mk(1,0,1,  0,  0,0,0,  7,1,1, 0,0,0,0)); // lw x7
    vecs.push_back(mk(1,0,1, 12,  7,1,1, 13,1,0, 1,0,0,1)); // load-use stall
    vecs.push_back(mk(1,0,1, 12,  7,1,1, 13,1,0, 0,0,2,0)); // replay
    vecs.push_back(mk(1,0,1,  0,  0,0,0,  5,1,0, 0,0,0,0)); // x5 (older)
    vecs.push_back(mk(1,0,1,  0,  0,0,0,  5,1,0, 0,0,0,0)); // x5 (younger)
    vecs.push_back(mk(1,0,1,  5, 13,1,1,  0,0,0, 0,1,3,0)); // youngest wins
    vecs.push_back(mk(1,0,1,  0,  0,0,0,  8,1,1, 0,0,0,0)); // lw x8
    vecs.push_back(mk(0,0,1,  8,  0,1,0,  0,0,0, 1,0,0,0)); // frozen x3
    vecs.push_back(mk(0,0,1,  8,  0,1,0,  0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,1,  8,  5,1,1,  0,0,0, 1,0,0,0));
    vecs.push_back(mk(1,1,1,  8,  0,1,0,  0,0,0, 0,0,0,1)); // flush beats stall
    vecs.push_back(mk(1,0,1,  8,  0,1,0,  0,0,0, 0,2,0,0)); // x8 now in M
    vecs.push_back(mk(1,0,0,  8,  8,1,1,  0,0,0, 0,0,0,1)); // id_valid=0

    repeat (2) @(negedge clk);
    #1;
    check("reset.stall", 32'(bus.load_use_stall), 32'd0);
    check_regs("reset", 0, 0, 1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d.stall", i), 32'(bus.load_use_stall), 32'(vecs[i].stall));
      @(posedge clk);
      #1;
      check_regs($sformatf("v%0d", i), vecs[i].sa, vecs[i].sb, vecs[i].bub);
    end

    // Async reset in the middle of a load-use stall, away from any clock edge.
    @(negedge clk);
    drive(mk(1,0,1, 0,0,0,0, 3,1,0, 0,0,0,0));
    @(negedge clk);
    drive(mk(1,0,1, 3,0,1,0, 7,1,1, 0,0,0,0)); // lw x7 using x3
    @(negedge clk);
    drive(mk(1,0,1, 0,7,0,1, 9,1,0, 0,0,0,0));
    #1;
    check("pre_rst.stall", 32'(bus.load_use_stall), 32'd1);
    check_regs("pre_rst", 1, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst.stall", 32'(bus.load_use_stall), 32'd0);
    check_regs("mid_rst", 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs("post_rst", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
